// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side status and stage-control bundle for the hazard controller.
// The pipeline is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned RF_ADDRESS = 5
);
   logic [RF_ADDRESS-1:0] id_rs1, id_rs2;
   logic                  id_use_rs1, id_use_rs2;
   logic [RF_ADDRESS-1:0] ex_rs1, ex_rs2, ex_rd;
   logic                  ex_memread, ex_mc, ex_mc_done, br_taken;
   logic [RF_ADDRESS-1:0] mem_rd;
   logic                  mem_regwrite, mem_req, mem_ready;
   logic [RF_ADDRESS-1:0] wb_rd;
   logic                  wb_regwrite;

   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic byp_a, byp_b;
   logic ex_mc_go;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_memread, ex_mc, ex_mc_done, br_taken, mem_rd, mem_regwrite,
             mem_req, mem_ready, wb_rd, wb_regwrite,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             fwd_a, fwd_b, byp_a, byp_b, ex_mc_go
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_memread, ex_mc, ex_mc_done, br_taken, mem_rd, mem_regwrite,
             mem_req, mem_ready, wb_rd, wb_regwrite,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             fwd_a, fwd_b, byp_a, byp_b, ex_mc_go
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline, with
// wait-state memory, multicycle EX ops, WB->ID bypass, timeout and perf counters.
module pipe_hazard_ctrl #(
   parameter int unsigned RF_ADDRESS  = 5,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave hz,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       state
);
   typedef enum logic [1:0] {
      RUN      = 2'b00,
      EX_BUSY  = 2'b01,
      MEM_WAIT = 2'b10
   } state_t;

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state_q, state_d;
   logic              go_q, mc_started;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_freeze, ex_stall, load_use, br_flush, stalled;

   function automatic logic match(input logic [RF_ADDRESS-1:0] src,
                                  input logic [RF_ADDRESS-1:0] rd,
                                  input logic                  we);
      return we && (rd != '0) && (rd == src);
   endfunction

   assign mem_freeze = hz.mem_req & ~hz.mem_ready;
   assign ex_stall   = hz.ex_mc & ~hz.ex_mc_done;
   assign load_use   = hz.ex_memread &
                       ((hz.id_use_rs1 & match(hz.id_rs1, hz.ex_rd, 1'b1)) |
                        (hz.id_use_rs2 & match(hz.id_rs2, hz.ex_rd, 1'b1)));
   assign br_flush   = ~reset & ~mem_freeze & ~ex_stall & hz.br_taken;
   assign stalled    = ~hz.pc_en;

   always_comb begin
      hz.pc_en        = 1'b1;
      hz.if_id_en     = 1'b1;
      hz.id_ex_en     = 1'b1;
      hz.ex_mem_en    = 1'b1;
      hz.mem_wb_en    = 1'b1;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_flush = 1'b0;
      hz.mem_wb_flush = 1'b0;
      if (reset) begin
         hz.if_id_flush  = 1'b1;
         hz.id_ex_flush  = 1'b1;
         hz.ex_mem_flush = 1'b1;
         hz.mem_wb_flush = 1'b1;
      end else if (mem_freeze) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_en     = 1'b0;
         hz.ex_mem_en    = 1'b0;
         hz.mem_wb_en    = 1'b0;
         hz.mem_wb_flush = 1'b1;
      end else if (ex_stall) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_en     = 1'b0;
         hz.ex_mem_flush = 1'b1;
      end else if (hz.br_taken) begin
         hz.if_id_flush  = 1'b1;
         hz.id_ex_flush  = (FLUSH_DEPTH == 2);
      end else if (load_use) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_flush  = 1'b1;
      end
   end

   // EX/MEM match outranks MEM/WB since it carries the younger value
   always_comb begin
      hz.fwd_a = 2'b00;
      hz.fwd_b = 2'b00;
      hz.byp_a = 1'b0;
      hz.byp_b = 1'b0;
      if (!reset) begin
         if (match(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite))     hz.fwd_a = 2'b10;
         else if (match(hz.ex_rs1, hz.wb_rd, hz.wb_regwrite))  hz.fwd_a = 2'b01;
         if (match(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite))     hz.fwd_b = 2'b10;
         else if (match(hz.ex_rs2, hz.wb_rd, hz.wb_regwrite))  hz.fwd_b = 2'b01;
         hz.byp_a = match(hz.id_rs1, hz.wb_rd, hz.wb_regwrite);
         hz.byp_b = match(hz.id_rs2, hz.wb_rd, hz.wb_regwrite);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (mem_freeze) state_d = MEM_WAIT;
                   else if (ex_stall) state_d = EX_BUSY;
         EX_BUSY:  if (mem_freeze) state_d = MEM_WAIT;
                   else if (!ex_stall) state_d = RUN;
         MEM_WAIT: if (!mem_freeze) state_d = ex_stall ? EX_BUSY : RUN;
         default:  state_d = RUN;
      endcase
   end

   // mc_started remembers an issued go across a MEM_WAIT detour
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         go_q       <= 1'b0;
         mc_started <= 1'b0;
         wait_cnt   <= '0;
         mem_err    <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         state_q <= state_d;
         go_q    <= (state_d == EX_BUSY) && (state_q != EX_BUSY) && !mc_started;
         if (state_d == RUN)
            mc_started <= 1'b0;
         else if (state_d == EX_BUSY)
            mc_started <= 1'b1;
         if (state_d == MEM_WAIT) begin
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (stalled && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (br_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz.ex_mc_go = go_q;
   assign state       = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table for the combinational
// priority/forwarding logic plus hand-written multicycle sequences.
module tb_pipe_hazard_ctrl;
   localparam logic [1:0] S_RUN = 2'b00, S_EXB = 2'b01, S_MEMW = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  state;

   pipe_hazard_ctrl_if #(.RF_ADDRESS(5)) hz ();

   pipe_hazard_ctrl #(
      .RF_ADDRESS(5), .CNT_W(16), .FLUSH_DEPTH(2), .MEM_TIMEOUT(64)
   ) dut (
      .clk(clk), .reset(reset), .hz(hz), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] id_rs1, id_rs2;
      logic       id_use_rs1, id_use_rs2;
      logic [4:0] ex_rs1, ex_rs2, ex_rd;
      logic       ex_memread, ex_mc, ex_mc_done, br_taken;
      logic [4:0] mem_rd;
      logic       mem_regwrite, mem_req, mem_ready;
      logic [4:0] wb_rd;
      logic       wb_regwrite;
   } in_t;

   typedef struct {
      logic [4:0] en;   // pc, if_id, id_ex, ex_mem, mem_wb
      logic [3:0] fl;   // if_id, id_ex, ex_mem, mem_wb
      logic [1:0] fa, fb;
      logic       ba, bb;
   } exp_t;

   typedef struct {
      string nm;
      in_t   i;
      exp_t  e;
   } vec_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_stall, exp_flush;
   in_t  v;

   function automatic in_t idle();
      in_t r;
      r = '{default: '0};
      r.mem_ready = 1'b1;
      return r;
   endfunction

   function automatic exp_t mk_e(logic [4:0] en, logic [3:0] fl, logic [1:0] fa,
                                 logic [1:0] fb, logic ba, logic bb);
      exp_t r;
      r.en = en; r.fl = fl; r.fa = fa; r.fb = fb; r.ba = ba; r.bb = bb;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic drive(input in_t d);
      hz.id_rs1 = d.id_rs1;         hz.id_rs2 = d.id_rs2;
      hz.id_use_rs1 = d.id_use_rs1; hz.id_use_rs2 = d.id_use_rs2;
      hz.ex_rs1 = d.ex_rs1;         hz.ex_rs2 = d.ex_rs2;
      hz.ex_rd = d.ex_rd;           hz.ex_memread = d.ex_memread;
      hz.ex_mc = d.ex_mc;           hz.ex_mc_done = d.ex_mc_done;
      hz.br_taken = d.br_taken;     hz.mem_rd = d.mem_rd;
      hz.mem_regwrite = d.mem_regwrite;
      hz.mem_req = d.mem_req;       hz.mem_ready = d.mem_ready;
      hz.wb_rd = d.wb_rd;           hz.wb_regwrite = d.wb_regwrite;
   endtask

   task automatic check_comb(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         chk({nm, " sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({nm, " en"}, {27'd0, hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en}, {27'd0, e.en});
      chk({nm, " flush"}, {28'd0, hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush}, {28'd0, e.fl});
      chk({nm, " fwd"}, {28'd0, hz.fwd_a, hz.fwd_b}, {28'd0, e.fa, e.fb});
      chk({nm, " byp"}, {30'd0, hz.byp_a, hz.byp_b}, {30'd0, e.ba, e.bb});
   endtask

   // drive one cycle on the falling edge, compare comb outputs before the rising edge
   task automatic cycle(input in_t d, input exp_t e, input string nm);
      @(negedge clk);
      drive(d);
      sb.push_back(e);
      if (e.en[4] == 1'b0) exp_stall++;
      if (e.fl[3] == 1'b1) exp_flush++;
      #2;
      check_comb(nm);
   endtask

   task automatic post(input string nm, input logic [1:0] st, input logic go, input logic err);
      @(posedge clk);
      #1;
      chk({nm, " state"}, {30'd0, state}, {30'd0, st});
      chk({nm, " go"}, {31'd0, hz.ex_mc_go}, {31'd0, go});
      chk({nm, " mem_err"}, {31'd0, mem_err}, {31'd0, err});
   endtask

   task automatic do_reset(input in_t d, input string nm);
      @(negedge clk);
      reset = 1'b1;
      drive(d);
      sb.push_back(mk_e(5'b11111, 4'b1111, 2'b00, 2'b00, 1'b0, 1'b0));
      #2;
      check_comb({nm, " rst"});
      post({nm, " rst"}, S_RUN, 1'b0, 1'b0);
      chk({nm, " rst stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
      chk({nm, " rst flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
      exp_stall = 0;
      exp_flush = 0;
      @(negedge clk);
      reset = 1'b0;
      drive(idle());
   endtask

   task automatic add(input string nm, input in_t i, input exp_t e);
      vec_t t;
      t.nm = nm; t.i = i; t.e = e;
      tbl.push_back(t);
   endtask

   initial begin
      exp_t E_IDLE, E_FRZ, E_EXST, E_BR, E_LU;
      E_IDLE = mk_e(5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);
      E_FRZ  = mk_e(5'b00000, 4'b0001, 2'b00, 2'b00, 1'b0, 1'b0);
      E_EXST = mk_e(5'b00011, 4'b0010, 2'b00, 2'b00, 1'b0, 1'b0);
      E_BR   = mk_e(5'b11111, 4'b1100, 2'b00, 2'b00, 1'b0, 1'b0);
      E_LU   = mk_e(5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);

      v = idle();                                           add("idle", v, E_IDLE);
      v = idle(); v.ex_rs1 = 1; v.mem_rd = 1; v.mem_regwrite = 1;
      add("fwd_mem_a", v, mk_e(5'b11111, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0));
      v = idle(); v.ex_rs1 = 1; v.id_rs1 = 1; v.wb_rd = 1; v.wb_regwrite = 1;
      add("fwd_wb_a", v, mk_e(5'b11111, 4'b0000, 2'b01, 2'b00, 1'b1, 1'b0));
      v = idle(); v.ex_rs2 = 3; v.id_rs2 = 3; v.mem_rd = 3; v.mem_regwrite = 1; v.wb_rd = 3; v.wb_regwrite = 1;
      add("fwd_prio_b", v, mk_e(5'b11111, 4'b0000, 2'b00, 2'b10, 1'b0, 1'b1));
      v = idle(); v.mem_regwrite = 1; v.wb_regwrite = 1;
      add("rd_x0", v, E_IDLE);
      v = idle(); v.ex_rs1 = 4; v.ex_rs2 = 4; v.id_rs1 = 4; v.mem_rd = 4; v.wb_rd = 4;
      add("no_regwrite", v, E_IDLE);
      v = idle(); v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
      add("load_use_rs1", v, E_LU);
      v = idle(); v.ex_memread = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_use_rs2 = 1;
      add("load_use_rs2", v, E_LU);
      v = idle(); v.ex_memread = 1; v.ex_rd = 5; v.id_rs2 = 5;
      add("load_nouse", v, E_IDLE);
      v = idle(); v.ex_memread = 1; v.id_use_rs1 = 1;
      add("load_x0", v, E_IDLE);
      v = idle(); v.br_taken = 1;                           add("branch", v, E_BR);
      v.ex_memread = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
      add("branch_over_lu", v, E_BR);
      v = idle(); v.ex_mc = 1;                              add("ex_stall", v, E_EXST);
      v.br_taken = 1;                                       add("ex_stall_br", v, E_EXST);
      v = idle(); v.ex_mc = 1; v.ex_mc_done = 1;            add("mc_done", v, E_IDLE);
      v = idle(); v.mem_req = 1; v.mem_ready = 0;           add("mem_freeze", v, E_FRZ);
      v.ex_mc = 1; v.br_taken = 1;                          add("freeze_all", v, E_FRZ);
      v = idle(); v.mem_req = 1;                            add("mem_ready", v, E_IDLE);
      v = idle(); v.mem_req = 1; v.mem_ready = 0; v.ex_rs1 = 7; v.mem_rd = 7; v.mem_regwrite = 1;
      add("freeze_fwd", v, mk_e(5'b00000, 4'b0001, 2'b10, 2'b00, 1'b0, 1'b0));
      v = idle();                                           add("idle_end", v, E_IDLE);

      reset = 1'b1;
      drive(idle());
      do_reset(idle(), "init");

      for (int unsigned k = 0; k < tbl.size(); k++)
         cycle(tbl[k].i, tbl[k].e, tbl[k].nm);
      @(posedge clk); #1;
      chk("table stall_cnt", {16'd0, stall_cnt}, exp_stall);
      chk("table flush_cnt", {16'd0, flush_cnt}, exp_flush);

      // add x1 / add x2,x1 / add x3,x1
      do_reset(idle(), "chain");
      v = idle(); v.ex_rd = 1;                              cycle(v, E_IDLE, "chain1");
      v = idle(); v.ex_rs1 = 1; v.ex_rd = 2; v.mem_rd = 1; v.mem_regwrite = 1;
      cycle(v, mk_e(5'b11111, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0), "chain2");
      v = idle(); v.ex_rs1 = 1; v.ex_rd = 3; v.mem_rd = 2; v.mem_regwrite = 1; v.wb_rd = 1; v.wb_regwrite = 1;
      cycle(v, mk_e(5'b11111, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0), "chain3");
      @(posedge clk); #1;
      chk("chain stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // lw x5 / add x6,x5,x0
      do_reset(idle(), "lw");
      v = idle(); v.ex_memread = 1; v.ex_rs1 = 2; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1; v.id_use_rs2 = 1;
      cycle(v, E_LU, "lw1");
      v = idle(); v.id_rs1 = 5; v.id_use_rs1 = 1; v.id_use_rs2 = 1; v.mem_rd = 5; v.mem_regwrite = 1; v.mem_req = 1;
      cycle(v, E_IDLE, "lw2");
      v = idle(); v.ex_rs1 = 5; v.ex_rd = 6; v.wb_rd = 5; v.wb_regwrite = 1;
      cycle(v, mk_e(5'b11111, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0), "lw3");
      @(posedge clk); #1;
      chk("lw stall_cnt", {16'd0, stall_cnt}, 32'd1);

      // branch alone: single flush event
      do_reset(idle(), "br");
      v = idle(); v.br_taken = 1;                           cycle(v, E_BR, "br1");
      cycle(idle(), E_IDLE, "br2");
      @(posedge clk); #1;
      chk("br flush_cnt", {16'd0, flush_cnt}, 32'd1);

      // multicycle op finishing after 5 stall cycles
      do_reset(idle(), "mc");
      v = idle(); v.ex_mc = 1;
      for (int unsigned k = 0; k < 6; k++) begin
         v.ex_mc_done = (k == 5);
         cycle(v, (k < 5) ? E_EXST : E_IDLE, "mc");
         post("mc", (k == 5) ? S_RUN : S_EXB, (k == 0), 1'b0);
      end
      chk("mc stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // memory wait in the middle of a multicycle op
      do_reset(idle(), "mcmem");
      v = idle(); v.ex_mc = 1;
      cycle(v, E_EXST, "mcmem0");          post("mcmem0", S_EXB, 1'b1, 1'b0);
      v.mem_req = 1; v.mem_ready = 0;
      for (int unsigned k = 0; k < 3; k++) begin
         cycle(v, E_FRZ, "mcmem_frz");     post("mcmem_frz", S_MEMW, 1'b0, 1'b0);
      end
      v.mem_ready = 1;
      cycle(v, E_EXST, "mcmem_rdy");       post("mcmem_rdy", S_EXB, 1'b0, 1'b0);
      v.ex_mc_done = 1; v.mem_req = 0;
      cycle(v, E_IDLE, "mcmem_done");      post("mcmem_done", S_RUN, 1'b0, 1'b0);
      chk("mcmem stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // memory never ready: timeout after 64 wait cycles, then reset mid-wait
      do_reset(idle(), "tmo");
      v = idle(); v.mem_req = 1; v.mem_ready = 0;
      for (int unsigned k = 1; k <= 70; k++) begin
         cycle(v, E_FRZ, "tmo");
         post("tmo", S_MEMW, 1'b0, (k >= 64));
      end
      chk("tmo stall_cnt", {16'd0, stall_cnt}, 32'd70);
      do_reset(v, "tmo_abort");
      cycle(idle(), E_IDLE, "after_abort");
      post("after_abort", S_RUN, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
